// File: rtl/stream_adder_pkg.sv
// Shared types and widths for the two-stage stream adder.
// Stage-1 fields are sized for the widest supported half (DATA_WIDTH <= 62).
package stream_adder_pkg;

   localparam int HALF_MAXW = 32;

   function automatic int lo_width(input int data_width);
      return data_width / 2;
   endfunction

   typedef struct packed {
      logic [HALF_MAXW-1:0] lo_sum;
      logic                 carry;
      logic [HALF_MAXW-1:0] a_hi;
      logic [HALF_MAXW-1:0] b_hi;
      logic                 sub;
      logic                 valid;
   } s1_t;

endpackage

// File: rtl/stream_adder_carry_slice.sv
// Half-width adder slice; inverting b with cin=1 gives a-b.
module carry_slice
   import stream_adder_pkg::*;
#(
   parameter int W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   input  logic         inv_b,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W-1:0] b_eff;
   logic [W:0]   total;

   always_comb begin
      b_eff = inv_b ? ~b : b;
      total = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};
   end

   assign sum  = total[W-1:0];
   assign cout = total[W];

endmodule

// File: rtl/stream_adder.sv
// Two-stage valid/ready add/sub pipeline, low half then high half.
// Optional STREAM_ADDER_STATS_EN adds xfer_count and carry_seen outputs.
module stream_adder
   import stream_adder_pkg::*;
#(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic                  sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH:0]   X
`ifdef STREAM_ADDER_STATS_EN
   ,
   output logic [15:0]           xfer_count,
   output logic                  carry_seen
`endif
);

   localparam int HW = lo_width(DATA_WIDTH);

   s1_t               s1_q, s1_d;
   logic [DATA_WIDTH:0] x_q, x_d;
   logic              out_valid_q, out_valid_d;
   logic              en;
   logic [HW-1:0]     lo_sum, hi_sum;
   logic              lo_cout, hi_cout;

   assign en       = out_ready || !out_valid_q;
   assign in_ready = en;

   carry_slice #(.W(HW)) u_lo (
      .a     (A[HW-1:0]),
      .b     (B[HW-1:0]),
      .cin   (sub),
      .inv_b (sub),
      .sum   (lo_sum),
      .cout  (lo_cout)
   );

   carry_slice #(.W(HW)) u_hi (
      .a     (s1_q.a_hi[HW-1:0]),
      .b     (s1_q.b_hi[HW-1:0]),
      .cin   (s1_q.carry),
      .inv_b (s1_q.sub),
      .sum   (hi_sum),
      .cout  (hi_cout)
   );

   always_comb begin
      s1_d        = s1_q;
      x_d         = x_q;
      out_valid_d = out_valid_q;
      if (en) begin
         s1_d                  = '0;
         s1_d.valid            = in_valid;
         s1_d.sub              = sub;
         s1_d.carry            = lo_cout;
         s1_d.lo_sum[HW-1:0]   = lo_sum;
         s1_d.a_hi[HW-1:0]     = A[DATA_WIDTH-1:HW];
         s1_d.b_hi[HW-1:0]     = B[DATA_WIDTH-1:HW];
         out_valid_d           = s1_q.valid;
         // The extra bit is carry for add, borrow (A<B) for subtract.
         if (s1_q.valid)
            x_d = {hi_cout ^ s1_q.sub, hi_sum, s1_q.lo_sum[HW-1:0]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q        <= '0;
         x_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         x_q         <= x_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign X         = x_q;

   logic unused_hi;
   assign unused_hi = ^{s1_q.lo_sum[HALF_MAXW-1:HW],
                        s1_q.a_hi[HALF_MAXW-1:HW],
                        s1_q.b_hi[HALF_MAXW-1:HW]};

`ifdef STREAM_ADDER_STATS_EN
   logic [15:0] xfer_count_q, xfer_count_d;
   logic        carry_seen_q, carry_seen_d;

   always_comb begin
      xfer_count_d = xfer_count_q;
      carry_seen_d = carry_seen_q;
      if (out_valid_q && out_ready) begin
         xfer_count_d = xfer_count_q + 16'd1;
         if (x_q[DATA_WIDTH])
            carry_seen_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xfer_count_q <= '0;
         carry_seen_q <= 1'b0;
      end else begin
         xfer_count_q <= xfer_count_d;
         carry_seen_q <= carry_seen_d;
      end
   end

   assign xfer_count = xfer_count_q;
   assign carry_seen = carry_seen_q;
`endif

endmodule

// File: tb/tb_stream_adder.sv
// Self-checking bench for stream_adder: vector table, scoreboard, corner sequences.
// Build with STREAM_ADDER_STATS_EN to also check the statistics outputs.
module tb_stream_adder;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, sub, out_valid, out_ready;
   logic [W-1:0] A, B;
   logic [W:0]   X;

   logic         in_valid8, in_ready8, sub8, out_valid8;
   logic         out_ready8;
   logic [7:0]   A8, B8;
   logic [8:0]   X8;

`ifdef STREAM_ADDER_STATS_EN
   logic [15:0]  xfer_count, xfer_count8;
   logic         carry_seen, carry_seen8;
`endif

   stream_adder #(.DATA_WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .X         (X)
`ifdef STREAM_ADDER_STATS_EN
      ,
      .xfer_count(xfer_count),
      .carry_seen(carry_seen)
`endif
   );

   stream_adder #(.DATA_WIDTH(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .A         (A8),
      .B         (B8),
      .sub       (sub8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .X         (X8)
`ifdef STREAM_ADDER_STATS_EN
      ,
      .xfer_count(xfer_count8),
      .carry_seen(carry_seen8)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int q[$];
   int n_out    = 0;
   bit stalled  = 0;
   logic [W:0] x_hold;

   typedef struct {
      int a;
      int b;
      bit s;
      int exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Width-(W+1) result from plain integer arithmetic.
   function automatic int model(input int a, input int b, input bit s);
      int m;
      m = 1 << (W + 1);
      if (s)
         return ((a - b) % m + m) % m;
      return a + b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every transfer must match the oldest accepted pair.
   always @(negedge clk) begin
      int e;
      if (rst) begin
         q.delete();
         stalled = 0;
      end else begin
         if (stalled && out_valid)
            chk("x_frozen", 32'(X), 32'(x_hold));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("out_without_input", 32'(q.size()), 1);
            end else begin
               e = q.pop_front();
               chk("scoreboard_x", 32'(X), 32'(e));
            end
            n_out++;
         end
         if (in_valid && in_ready)
            q.push_back(model(int'(A), int'(B), sub));
         stalled = out_valid && !out_ready;
         x_hold  = X;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[$];
      int   base, k, guard;
      int   pa[3], pb[3];
      bit   ps[3];
      bit   acc;

      vecs.push_back('{9, 8, 0, 17});
      vecs.push_back('{3, 5, 1, 30});
      vecs.push_back('{5, 3, 1, 2});
      vecs.push_back('{0, 0, 0, 0});
      vecs.push_back('{15, 15, 0, 30});
      vecs.push_back('{0, 15, 1, 17});
      vecs.push_back('{15, 0, 1, 15});
      vecs.push_back('{7, 7, 1, 0});
      vecs.push_back('{15, 1, 0, 16});

      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      A          = '0;
      B          = '0;
      sub        = 1'b0;
      in_valid8  = 1'b0;
      out_ready8 = 1'b1;
      A8         = '0;
      B8         = '0;
      sub8       = 1'b0;

      repeat (3) tick();
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_x", 32'(X), 0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", 32'(in_ready), 1);

      foreach (vecs[i]) begin
         in_valid = 1'b1;
         A        = W'(vecs[i].a);
         B        = W'(vecs[i].b);
         sub      = vecs[i].s;
         tick();
         in_valid = 1'b0;
         chk("vec_latency1_valid", 32'(out_valid), 0);
         tick();
         chk("vec_latency2_valid", 32'(out_valid), 1);
         chk("vec_x", 32'(X), 32'(vecs[i].exp));
         tick();
      end

      in_valid8 = 1'b1;
      A8        = 8'd255;
      B8        = 8'd1;
      sub8      = 1'b0;
      tick();
      A8        = 8'd0;
      B8        = 8'd255;
      sub8      = 1'b1;
      tick();
      in_valid8 = 1'b0;
      chk("w8_add_valid", 32'(out_valid8), 1);
      chk("w8_add_x", 32'(X8), 32'h100);
      tick();
      chk("w8_sub_x", 32'(X8), 32'h101);

      base = n_out;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         A        = W'(i);
         B        = W'(15 - i);
         sub      = 1'b0;
         chk("stream_in_ready", 32'(in_ready), 1);
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();
      chk("stream_count", 32'(n_out - base), 16);

      pa = '{2, 10, 6};
      pb = '{3, 4, 9};
      ps = '{0, 1, 1};
      base      = n_out;
      k         = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         in_valid = (k < 3);
         A        = W'(pa[k % 3]);
         B        = W'(pb[k % 3]);
         sub      = ps[k % 3];
         #1;
         if (out_valid)
            chk("stall_in_ready_low", 32'(in_ready), 0);
         acc = in_valid && in_ready;
         tick();
         if (acc)
            k++;
      end
      chk("stall_no_output", 32'(n_out - base), 0);
      out_ready = 1'b1;
      guard     = 0;
      while (k < 3 && guard < 20) begin
         in_valid = 1'b1;
         A        = W'(pa[k]);
         B        = W'(pb[k]);
         sub      = ps[k];
         #1;
         acc = in_ready;
         tick();
         if (acc)
            k++;
         guard++;
      end
      in_valid = 1'b0;
      chk("stall_all_accepted", 32'(k), 3);
      repeat (4) tick();
      chk("stall_delivered", 32'(n_out - base), 3);

      for (int c = 0; c < 300; c++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         A         = W'($urandom_range(15));
         B         = W'($urandom_range(15));
         sub       = 1'($urandom_range(1));
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
      chk("random_drained", 32'(q.size()), 0);

      out_ready = 1'b0;
      in_valid  = 1'b1;
      A         = 4'd4;
      B         = 4'd4;
      sub       = 1'b0;
      tick();
      A         = 4'd7;
      B         = 4'd1;
      tick();
      in_valid  = 1'b0;
      chk("inflight_valid", 32'(out_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(out_valid), 0);
      chk("async_rst_x", 32'(X), 0);
      chk("async_rst_in_ready", 32'(in_ready), 1);
      tick();
      rst       = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      A         = 4'd1;
      B         = 4'd1;
      sub       = 1'b0;
      tick();
      in_valid  = 1'b0;
      chk("after_rst_lat1", 32'(out_valid), 0);
      tick();
      chk("after_rst_valid", 32'(out_valid), 1);
      chk("after_rst_x", 32'(X), 2);
      tick();

`ifdef STREAM_ADDER_STATS_EN
      chk("stats_count1", 32'(xfer_count), 1);
      chk("stats_carry_clear", 32'(carry_seen), 0);
      in_valid = 1'b1;
      A        = 4'd15;
      B        = 4'd15;
      tick();
      A        = 4'd3;
      B        = 4'd4;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      chk("stats_count3", 32'(xfer_count), 3);
      chk("stats_carry_seen", 32'(carry_seen), 1);
`endif

      chk("final_queue_empty", 32'(q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
